karatsuba_seq_ctrl: RTL and testbench

Sequencing controller that computes a 32x32 unsigned product by time-multiplexing a single `karatsuba_16` combinational multiplier over four 16x16 partial products. It accumulates the partial products into a 64-bit result. A valid/ready handshake is used on both the input and output sides. The block sits between an operand producer and a result consumer and is the only user of its `karatsuba_16` instance.

---
 rtl/kara_pkg.sv | 29 ++
 rtl/karatsuba_16.sv | 34 +++
 rtl/karatsuba_seq_ctrl.sv | 96 +++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kara_pkg.sv
// rtl/kara_pkg.sv - shared widths, FSM encoding, step type and shift table for the Karatsuba sequencer
package kara_pkg;

   localparam int KARA_H = 16;
   localparam int KARA_W = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_MUL  = S_MUL,
      ST_DONE = S_DONE
   } kara_state_t;

   typedef logic [1:0] step_t;

   // Left shift applied to the partial product of each step s0..s3
   localparam int unsigned KARA_SHIFT [4] = '{0, 16, 16, 32};

   function automatic step_t first_pending(input logic [3:0] mask);
      if (mask[0])      return 2'd0;
      else if (mask[1]) return 2'd1;
      else if (mask[2]) return 2'd2;
      else              return 2'd3;
   endfunction

endpackage

// File: rtl/karatsuba_16.sv
// rtl/karatsuba_16.sv - combinational one-level Karatsuba N x N unsigned multiplier
module karatsuba_16 #(
   parameter int N = 16
) (
   input  logic [N-1:0]   X,
   input  logic [N-1:0]   Y,
   output logic [2*N-1:0] Z
);

   localparam int M = N / 2;

   logic [M-1:0]     xl, xh, yl, yh;
   logic [M:0]       xs, ys;
   logic [2*M-1:0]   z0, z2;
   logic [2*M+1:0]   zm, z1;

   assign xl = X[M-1:0];
   assign xh = X[N-1:M];
   assign yl = Y[M-1:0];
   assign yh = Y[N-1:M];

   assign xs = {1'b0, xl} + {1'b0, xh};
   assign ys = {1'b0, yl} + {1'b0, yh};

   assign z0 = {{M{1'b0}}, xl} * {{M{1'b0}}, yl};
   assign z2 = {{M{1'b0}}, xh} * {{M{1'b0}}, yh};
   assign zm = {{(M+1){1'b0}}, xs} * {{(M+1){1'b0}}, ys};

   // Cross term xl*yh + xh*yl recovered from the sum product; never negative
   assign z1 = zm - {2'b00, z0} - {2'b00, z2};

   assign Z = {z2, z0} + ({{(2*N-2*M-2){1'b0}}, z1} << M);

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// rtl/karatsuba_seq_ctrl.sv - 32x32 product from four sequenced 16x16 partials; KARA_SEQ_ZERO_SKIP_EN skips zero-half steps
module karatsuba_seq_ctrl
   import kara_pkg::*;
#(
   parameter int W = KARA_W,
   parameter int H = KARA_H
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] p,
   output logic           busy
);

   kara_state_t    state;
   step_t          step;
   logic [3:0]     mask;
   logic [3:0]     mask_load;
   logic [3:0]     mask_next;
   logic [W-1:0]   a_q, b_q;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] term;
   logic [H-1:0]   x, y;
   logic [2*H-1:0] z;

`ifdef KARA_SEQ_ZERO_SKIP_EN
   assign mask_load = {(|a[W-1:H]) && (|b[W-1:H]),
                       (|a[W-1:H]) && (|b[H-1:0]),
                       (|a[H-1:0]) && (|b[W-1:H]),
                       (|a[H-1:0]) && (|b[H-1:0])};
`else
   assign mask_load = 4'b1111;
`endif

   // step[1] picks the a half, step[0] the b half: s1 = a_lo*b_hi, s2 = a_hi*b_lo
   assign x = step[1] ? a_q[W-1:H] : a_q[H-1:0];
   assign y = step[0] ? b_q[W-1:H] : b_q[H-1:0];

   karatsuba_16 #(.N(H)) u_mul (
      .X(x),
      .Y(y),
      .Z(z)
   );

   assign term      = {{(2*W-2*H){1'b0}}, z} << KARA_SHIFT[step];
   assign mask_next = mask & ~(4'b0001 << step);

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign p         = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         step  <= 2'd0;
         mask  <= 4'b0000;
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  acc   <= '0;
                  mask  <= mask_load;
                  step  <= first_pending(mask_load);
                  state <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (mask == 4'b0000) begin
                  state <= ST_DONE;
               end else begin
                  acc  <= acc + term;
                  mask <= mask_next;
                  step <= first_pending(mask_next);
                  if (mask_next == 4'b0000) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// tb/tb_karatsuba_seq_ctrl.sv - scoreboard bench for karatsuba_seq_ctrl against a plain a*b model
module tb_karatsuba_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] p;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] prod;
      int          lat;
      int          acc_edge;
   } exp_t;

   exp_t sbq[$];

   karatsuba_seq_ctrl dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .p(p),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Latency from the operand rules: every nonzero-half step costs a cycle, minimum one
   function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef KARA_SEQ_ZERO_SKIP_EN
      int n;
      n = 0;
      if (x[15:0]  != 0 && y[15:0]  != 0) n++;
      if (x[15:0]  != 0 && y[31:16] != 0) n++;
      if (x[31:16] != 0 && y[15:0]  != 0) n++;
      if (x[31:16] != 0 && y[31:16] != 0) n++;
      return (n == 0) ? 1 : n;
`else
      return 4;
`endif
   endfunction

   function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y);
      return {32'd0, x} * {32'd0, y};
   endfunction

   // Monitor: latency on rising out_valid, hold stability, product on handoff
   logic        prev_ov = 1'b0;
   logic [63:0] prev_p  = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (sbq.size() == 0) check("unexpected_out_valid", 64'd1, 64'd0);
            else check("latency", 64'(cyc - sbq[0].acc_edge), 64'(sbq[0].lat));
         end
         if (out_valid && prev_ov) check("p_hold", p, prev_p);
         if (out_valid) check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) check("result_without_request", 64'd1, 64'd0);
            else begin
               check("product", p, sbq[0].prod);
               void'(sbq.pop_front());
            end
         end
         prev_ov = out_valid;
         prev_p  = p;
      end
   end

   task automatic wait_accept(input logic [31:0] x, input logic [31:0] y);
      int guard;
      a = x;
      b = y;
      in_valid = 1'b1;
      guard = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 50) begin
            check("accept_timeout", 64'd1, 64'd0);
            break;
         end
      end
      sbq.push_back('{model_prod(x, y), model_lat(x, y), cyc + 1});
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit rnd);
      int guard;
      if (rnd) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_accept(x, y);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      guard = 0;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) break;
         guard++;
         if (guard > 60) begin
            check("result_timeout", 64'd1, 64'd0);
            break;
         end
         @(posedge clk);
         #1;
         out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] x, y;
      logic [63:0] held;
      int          guard;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy",      {63'd0, busy},      64'd0);
      check("rst_p",         p,                  64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(32'h00000003, 32'h00000005, 1'b0);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      issue(32'h12345678, 32'h9ABCDEF0, 1'b0);
      issue(32'h00010000, 32'h00000002, 1'b0);
      issue(32'h00000000, 32'hDEADBEEF, 1'b0);
      issue(32'hFFFF0000, 32'h0000FFFF, 1'b0);
      issue(32'h0000FFFF, 32'hFFFF0000, 1'b0);

      for (int i = 0; i < 200; i++) begin
         x = $urandom;
         y = $urandom;
         if ($urandom % 5 == 0) x[15:0]  = '0;
         if ($urandom % 5 == 0) x[31:16] = '0;
         if ($urandom % 5 == 0) y[15:0]  = '0;
         if ($urandom % 5 == 0) y[31:16] = '0;
         issue(x, y, 1'b1);
      end

      // Back-pressure: result held in DONE while new operands are offered
      x = 32'hCAFEBABE;
      y = 32'h0BADF00D;
      out_ready = 1'b0;
      wait_accept(x, y);
      a = 32'h11111111;
      b = 32'h22222222;
      guard = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         guard++;
         if (guard > 20) begin
            check("hold_reach_done", 64'd1, 64'd0);
            break;
         end
      end
      held = model_prod(x, y);
      for (int i = 0; i < 10; i++) begin
         check("hold_out_valid", {63'd0, out_valid}, 64'd1);
         check("hold_in_ready",  {63'd0, in_ready},  64'd0);
         check("hold_p",         p,                  held);
         @(negedge clk);
      end
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_in_ready",  {63'd0, in_ready},  64'd1);
      check("release_out_valid", {63'd0, out_valid}, 64'd0);
      check("release_busy",      {63'd0, busy},      64'd0);

      // Reset while step s2 is about to execute
      wait_accept(32'h11112222, 32'h33334444);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("pre_abort_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      sbq.delete();
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_in_ready",  {63'd0, in_ready},  64'd1);
      check("abort_busy",      {63'd0, busy},      64'd0);
      check("abort_p",         p,                  64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(32'd7, 32'd9, 1'b0);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
